// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//
// Bit-serial magnitude comparator. Two WIDTH-bit operands are latched when a
// compare is accepted and then scanned MSB-first, one bit per clock. The
// compare can be unsigned or two's-complement signed. With EARLY_EXIT=1 it
// finishes on the first differing bit. With EARLY_EXIT=0 it always scans all
// WIDTH bits, which gives a fixed latency.
//
// Handshake: start is accepted on a rising edge only while busy=0, which is
// the same as state IDLE. busy is high from the accept edge up to the edge
// that finishes the compare. On the finish edge done rises for one cycle and
// gt/eq/lt take the new result. The flags then hold until the next done. A
// start seen while busy=1 is dropped, not queued.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        compare request, accepted when busy=0
//   signed_mode  0 = unsigned, 1 = two's complement (latched on accept)
//   a, b         operands (latched on accept)
//   busy         compare in progress
//   done         one-cycle result strobe
//   gt, eq, lt   last result (A>B, A==B, A<B)
//   dbg_state    current FSM state (0 = IDLE, 1 = SCAN)
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             dbg_state
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             pgt_q, pgt_d;   // pending result, valid once decided_q=1
  logic             plt_q, plt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  // Evaluation of the current bit during SCAN.
  logic bit_a, bit_b, bit_diff, new_decide, a_bit_wins;
  logic cur_gt, cur_lt, finish;

  always_comb begin
    bit_a      = a_q[idx_q];
    bit_b      = b_q[idx_q];
    bit_diff   = bit_a ^ bit_b;
    new_decide = bit_diff & ~decided_q;
    // The signed MSB carries negative weight, so a 1 there loses.
    if (mode_q && (idx_q == IDX_MAX)) a_bit_wins = ~bit_a;
    else                              a_bit_wins = bit_a;
    // The first mismatch wins. Once decided, later bits are ignored.
    if (decided_q) begin
      cur_gt = pgt_q;
      cur_lt = plt_q;
    end else begin
      cur_gt = new_decide & a_bit_wins;
      cur_lt = new_decide & ~a_bit_wins;
    end
    finish = ((EARLY_EXIT == 1'b1) && new_decide) || (idx_q == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      idx_q     <= IDX_MAX;
      decided_q <= 1'b0;
      pgt_q     <= 1'b0;
      plt_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      pgt_q     <= pgt_d;
      plt_q     <= plt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  // Next-state logic: FSM plus operand, index and decision registers.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    pgt_d     = pgt_q;
    plt_d     = plt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          mode_d    = signed_mode;
          idx_d     = IDX_MAX;
          decided_d = 1'b0;
          pgt_d     = 1'b0;
          plt_d     = 1'b0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        decided_d = decided_q | bit_diff;
        pgt_d     = cur_gt;
        plt_d     = cur_lt;
        if (finish) state_d = S_IDLE;
        else        idx_d   = idx_q - IW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: registered busy/done/flags.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    gt_d   = gt_q;
    eq_d   = eq_q;
    lt_d   = lt_q;
    case (state_q)
      S_IDLE: begin
        if (start) busy_d = 1'b1;
      end
      S_SCAN: begin
        if (finish) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          gt_d   = cur_gt;
          lt_d   = cur_lt;
          eq_d   = ~cur_gt & ~cur_lt;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic busy0, done0, gt0, eq0, lt0, st0;
  logic busy1, done1, gt1, eq1, lt1, st1;

  // Early-exit instance
  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0),
    .dbg_state(st0)
  );

  // Fixed-latency instance
  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1),
    .dbg_state(st1)
  );

  // Observation mux: sel=0 -> dut0, sel=1 -> dut1
  logic       sel = 1'b0;
  logic       obs_busy, obs_done;
  logic [2:0] obs_flags;
  assign obs_busy  = sel ? busy1 : busy0;
  assign obs_done  = sel ? done1 : done0;
  assign obs_flags = sel ? {gt1, eq1, lt1} : {gt0, eq0, lt0};

  int passed = 0;
  int total  = 0;

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accept a compare on one instance and follow it to done.
  // Checks latency in edges after E0, busy during scan/done, and flags {gt,eq,lt}.
  task automatic run_cmp(input bit fx, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm, input int exp_lat, input logic [2:0] exp_f,
                         input string tag);
    int lat;
    logic bad_busy;
    sel = fx;
    a = av;
    b = bv;
    signed_mode = sm;
    if (fx) start1 = 1'b1;
    else    start0 = 1'b1;
    tick();  // E0
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 0;
    bad_busy = 1'b0;
    while (!obs_done && lat < 20) begin
      if (obs_busy !== 1'b1) bad_busy = 1'b1;
      tick();
      lat++;
    end
    check({tag, " done seen"}, 32'(obs_done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " flags"}, 32'(obs_flags), 32'(exp_f));
    check({tag, " busy low at done"}, 32'(obs_busy), 32'd0);
    check({tag, " busy high in scan"}, 32'(bad_busy), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int n_done;

    // Reset, with start held high to show reset wins.
    rst_n  = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;
    tick();
    tick();
    check("reset dut0 outputs", 32'({busy0, done0, gt0, eq0, lt0}), 32'd0);
    check("reset dut1 outputs", 32'({busy1, done1, gt1, eq1, lt1}), 32'd0);
    start0 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    tick();
    check("idle after reset", 32'({busy0, busy1}), 32'd0);

    // Early exit instance. Flags are packed as {gt, eq, lt}.
    run_cmp(1'b0, 8'hA5, 8'h5A, 1'b0, 1, 3'b100, "u A5>5A");
    tick();
    check("done one cycle", 32'(done0), 32'd0);
    check("flags hold", 32'({gt0, eq0, lt0}), 32'b100);
    run_cmp(1'b0, 8'h3C, 8'h3C, 1'b0, 8, 3'b010, "eq 3C");
    run_cmp(1'b0, 8'h80, 8'h7F, 1'b1, 1, 3'b001, "s 80<7F");
    run_cmp(1'b0, 8'h80, 8'h7F, 1'b0, 1, 3'b100, "u 80>7F");
    run_cmp(1'b0, 8'hFE, 8'hFF, 1'b1, 8, 3'b001, "s FE<FF");
    run_cmp(1'b0, 8'h40, 8'h3F, 1'b0, 2, 3'b100, "u 40>3F ee");
    run_cmp(1'b0, 8'h00, 8'h80, 1'b1, 1, 3'b100, "s 00>80");

    // Fixed-latency instance
    run_cmp(1'b1, 8'h80, 8'h00, 1'b0, 8, 3'b100, "fix 80>00");
    run_cmp(1'b1, 8'h01, 8'h00, 1'b0, 8, 3'b100, "fix 01>00");
    run_cmp(1'b1, 8'h40, 8'h3F, 1'b0, 8, 3'b100, "fix 40>3F");
    run_cmp(1'b1, 8'h7F, 8'h80, 1'b1, 8, 3'b100, "fix s 7F>80");
    run_cmp(1'b1, 8'h55, 8'h55, 1'b1, 8, 3'b010, "fix eq 55");
    tick();

    // Ignored start at E2, operands changed mid-scan.
    sel = 1'b0;
    a = 8'h3C;
    b = 8'h3C;
    signed_mode = 1'b0;
    start0 = 1'b1;
    tick();            // E0
    start0 = 1'b0;
    a = 8'h00;
    b = 8'hFF;
    tick();            // E1
    start0 = 1'b1;
    tick();            // E2 (start ignored)
    start0 = 1'b0;
    a = 8'h11;
    b = 8'h22;
    signed_mode = 1'b1;
    for (int i = 3; i < 8; i++) tick();
    check("iso busy before done", 32'({busy0, done0}), 32'b10);
    tick();            // E8
    check("iso done at E8", 32'(done0), 32'd1);
    check("iso flags eq", 32'({gt0, eq0, lt0}), 32'b010);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done0 || busy0) n_done++;
    end
    check("no second compare", 32'(n_done), 32'd0);

    // Back-to-back: start in the done cycle.
    run_cmp(1'b0, 8'hA5, 8'h5A, 1'b0, 1, 3'b100, "b2b first");
    a = 8'h01;
    b = 8'h02;
    signed_mode = 1'b0;
    start0 = 1'b1;
    tick();            // E0 of second compare
    start0 = 1'b0;
    check("b2b accepted", 32'(busy0), 32'd1);
    check("b2b flags not cleared", 32'({gt0, eq0, lt0}), 32'b100);
    n_done = 0;
    while (!done0 && n_done < 20) begin
      tick();
      n_done++;
    end
    check("b2b second latency", 32'(n_done), 32'd7);
    check("b2b second flags", 32'({gt0, eq0, lt0}), 32'b001);
    tick();

    // Reset at E3 of an equal compare.
    a = 8'h3C;
    b = 8'h3C;
    start0 = 1'b1;
    tick();            // E0
    start0 = 1'b0;
    tick();            // E1
    tick();            // E2
    rst_n = 1'b0;
    tick();            // E3 with reset
    rst_n = 1'b1;
    check("reset mid-scan outputs", 32'({busy0, done0, gt0, eq0, lt0}), 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done0 || busy0) n_done++;
    end
    check("no done after abort", 32'(n_done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
